// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for the shift sequencer.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface shift_sequencer_if;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] data_in;
  logic [4:0] amount;
  logic [1:0] fn;
  logic       done_valid;
  logic       done_ready;
  logic [7:0] result;
  logic       c;
  logic       z;
  logic       busy;

  modport slave (
    input  start_valid, data_in, amount, fn, done_ready,
    output start_ready, done_valid, result, c, z, busy
  );

  modport master (
    output start_valid, data_in, amount, fn, done_ready,
    input  start_ready, done_valid, result, c, z, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 8-bit shifter/rotator: the shift amount is consumed in chunks of at most 7
// per cycle through a single shifter; carry tracks the last bit moved by each chunk.
module shift_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  bus,
  output logic [1:0]        state_o
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  work_q, work_d;
  logic [4:0]  rem_q, rem_d;
  logic [1:0]  fn_q, fn_d;
  logic        c_q, c_d;

  logic [2:0]  step;
  logic [2:0]  left_idx;
  logic [2:0]  right_idx;
  logic [15:0] dbl_l, dbl_r;
  logic [7:0]  shifted;
  logic        carry;

  // Single shifter; rotates come from the doubled operand so no second barrel is needed.
  always_comb begin
    step      = (rem_q > 5'd7) ? 3'd7 : rem_q[2:0];
    left_idx  = 3'(4'd8 - {1'b0, step});
    right_idx = step - 3'd1;
    dbl_l     = {work_q, work_q} << step;
    dbl_r     = {work_q, work_q} >> step;
    shifted   = work_q;
    carry     = c_q;
    case (fn_q)
      2'b00: begin
        shifted = work_q << step;
        carry   = work_q[left_idx];
      end
      2'b01: begin
        shifted = work_q >> step;
        carry   = work_q[right_idx];
      end
      2'b10: begin
        shifted = dbl_l[15:8];
        carry   = dbl_l[8];
      end
      default: begin
        shifted = dbl_r[7:0];
        carry   = dbl_r[7];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    fn_d    = fn_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          work_d  = bus.data_in;
          rem_d   = bus.amount;
          fn_d    = bus.fn;
          c_d     = 1'b0;
          state_d = (bus.amount == 5'd0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        c_d    = carry;
        rem_d  = rem_q - {2'b00, step};
        if (rem_d == 5'd0) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= 8'h00;
      rem_q   <= 5'd0;
      fn_q    <= 2'b00;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      fn_q    <= fn_d;
      c_q     <= c_d;
    end
  end

  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.done_valid  = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.result      = work_q;
  assign bus.c           = c_q;
  assign bus.z           = (work_q == 8'h00);
  assign state_o         = state_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;
  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-operation view: net effect of shifting/rotating by the full amount.
  task automatic model(input logic [7:0] d, input int a, input logic [1:0] f,
                       output logic [7:0] r, output logic cf, output int cyc);
    int v;
    int k;
    v   = d;
    k   = a % 8;
    cyc = (a + 6) / 7;
    case (f)
      2'b00: begin
        r  = (a >= 8) ? 8'h00 : 8'((v << a) & 255);
        cf = (a == 0 || a > 8) ? 1'b0 : d[8 - a];
      end
      2'b01: begin
        r  = (a >= 8) ? 8'h00 : 8'(v >> a);
        cf = (a == 0 || a > 8) ? 1'b0 : d[a - 1];
      end
      2'b10: begin
        r  = 8'(((v << k) | (v >> (8 - k))) & 255);
        cf = (a == 0) ? 1'b0 : r[0];
      end
      default: begin
        r  = 8'(((v >> k) | (v << (8 - k))) & 255);
        cf = (a == 0) ? 1'b0 : r[7];
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [7:0] d, input int a,
                        input logic [1:0] f, input int hold);
    logic [7:0] exp_r;
    logic       exp_c;
    int         exp_cyc;
    int         cnt;
    model(d, a, f, exp_r, exp_c, exp_cyc);
    check({tag, ".ready_before"}, 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.data_in     = d;
    bus.amount      = 5'(a);
    bus.fn          = f;
    tick();
    // Keep a request pending with junk operands while busy; it must not disturb anything.
    bus.data_in = 8'($urandom);
    bus.amount  = 5'($urandom);
    bus.fn      = 2'($urandom);
    cnt = 0;
    while (!bus.done_valid && cnt < 40) begin
      cnt++;
      bus.data_in = 8'($urandom);
      tick();
    end
    check({tag, ".shift_cycles"}, 32'(cnt), 32'(exp_cyc));
    check({tag, ".result"}, 32'(bus.result), 32'(exp_r));
    check({tag, ".c"}, 32'(bus.c), 32'(exp_c));
    check({tag, ".z"}, 32'(bus.z), 32'(exp_r == 8'h00));
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    check({tag, ".ready_in_done"}, 32'(bus.start_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_valid"}, 32'(bus.done_valid), 32'd1);
      check({tag, ".hold_result"}, 32'(bus.result), 32'(exp_r));
      check({tag, ".hold_c"}, 32'(bus.c), 32'(exp_c));
      check({tag, ".hold_ready"}, 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid = 1'b0;
    bus.done_ready  = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check({tag, ".ready_after"}, 32'(bus.start_ready), 32'd1);
    check({tag, ".valid_after"}, 32'(bus.done_valid), 32'd0);
    check({tag, ".busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.done_ready  = 1'b0;
    bus.data_in     = 8'h00;
    bus.amount      = 5'd0;
    bus.fn          = 2'b00;
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset.start_ready", 32'(bus.start_ready), 32'd1);
    check("reset.done_valid", 32'(bus.done_valid), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.result", 32'(bus.result), 32'h00);
    check("reset.c", 32'(bus.c), 32'd0);
    check("reset.z", 32'(bus.z), 32'd1);

    // done_ready outside DONE has no effect
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check("idle_done_ready.start_ready", 32'(bus.start_ready), 32'd1);
    check("idle_done_ready.done_valid", 32'(bus.done_valid), 32'd0);

    run_op("shl1", 8'h92, 1, 2'b00, 0);
    run_op("ror5", 8'h36, 5, 2'b11, 1);
    run_op("shl9", 8'h92, 9, 2'b00, 0);
    run_op("rol16", 8'h81, 16, 2'b10, 2);
    run_op("amt0_hold", 8'hA5, 0, 2'b01, 4);
    run_op("shr8", 8'hC3, 8, 2'b01, 0);
    run_op("shl8", 8'hC3, 8, 2'b00, 0);
    run_op("ror31", 8'h5A, 31, 2'b11, 1);
    run_op("shr7", 8'h80, 7, 2'b01, 0);

    for (int n = 0; n < 40; n++) begin
      run_op("rand", 8'($urandom), int'($urandom_range(0, 31)), 2'($urandom),
             int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a long shift abandons it.
    bus.start_valid = 1'b1;
    bus.data_in     = 8'hFF;
    bus.amount      = 5'd31;
    bus.fn          = 2'b10;
    tick();
    bus.start_valid = 1'b0;
    tick();
    check("midreset.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset.start_ready", 32'(bus.start_ready), 32'd1);
    check("midreset.result", 32'(bus.result), 32'h00);
    check("midreset.z", 32'(bus.z), 32'd1);
    check("midreset.c", 32'(bus.c), 32'd0);
    check("midreset.busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("midreset.no_done", 32'(bus.done_valid), 32'd0);
      tick();
    end
    run_op("after_reset", 8'h0F, 3, 2'b00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset; synchronous, active-low.
REQ-003 SHALL have ports: start_valid  in  1  request present.
REQ-004 SHALL have ports: start_ready  out  1  sequencer accepts request.
REQ-005 SHALL have ports: data_in  in  8  operand.
REQ-006 SHALL have ports: amount  in  5  total shift count, 0..31.
REQ-007 SHALL have ports: fn  in  2  00 shift left, 01 shift right (logical), 10 rotate left, 11 rotate right.
REQ-008 SHALL have ports: done_valid  out  1  result available.
REQ-009 SHALL have ports: done_ready  in  1  consumer takes result.
REQ-010 SHALL have ports: result  out  8  shifted operand.
REQ-011 SHALL have ports: c  out  1  carry flag.
REQ-012 SHALL have ports: z  out  1  zero flag, 1 iff result==0.
REQ-013 SHALL have ports: busy  out  1  high in SHIFT or DONE.

Function
REQ-014 SHALL implement the states IDLE, SHIFT and DONE; start_ready=1 only in IDLE; done_valid=1 only in DONE.
REQ-015 SHALL accept a request on start_valid&&start_ready and register data_in, amount and fn; later input changes SHALL NOT affect the operation in flight.
REQ-016 SHALL, on accept with amount==0, go IDLE->DONE with result=data_in and c=0.
REQ-017 SHALL, on accept with amount>0, go IDLE->SHIFT with remaining=amount.
REQ-018 SHALL, each SHIFT cycle, apply step=min(remaining,7) to the working register using one 8-bit shifter with sc=step, and set remaining-=step.
REQ-019 SHALL go SHIFT->DONE in the cycle where remaining reaches 0, so that SHIFT lasts ceil(amount/7) cycles.
REQ-020 SHALL update c on every step: fn 00 gives c=pre-step bit[8-step]; fn 01 gives c=pre-step bit[step-1]; fn 10 gives c=post-step bit[0]; fn 11 gives c=post-step bit[7].
REQ-021 SHALL fill vacated bits with 0 for shifts and wrap them for rotates; with amount>=8, a shift yields 0x00 and a rotate is equivalent to amount mod 8.
REQ-022 SHALL hold result, c and z stable throughout DONE until done_ready=1, then go DONE->IDLE; start_ready SHALL return to 1 in the following cycle.
REQ-023 SHALL compute z from result combinationally; result and c SHALL be registered.
REQ-024 SHALL ignore done_ready outside DONE and start_valid outside IDLE.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, force state=IDLE, result=0x00, c=0, remaining=0, done_valid=0 and busy=0, with start_ready=1 after that edge.
REQ-026 SHALL have z=1 after reset, because result=0.
REQ-027 SHALL abandon any in-flight SHIFT or DONE operation on reset, with no done_valid pulse for it.

Verification
REQ-028 SHALL be covered by: data 0x92, amount 1, fn 00 -> 1 SHIFT cycle; result 0x24, c=1, z=0.
REQ-029 SHALL be covered by: data 0x36, amount 5, fn 11 -> result 0xB1, c=1, z=0, 1 SHIFT cycle.
REQ-030 SHALL be covered by: data 0x92, amount 9, fn 00 -> steps 7 then 2; result 0x00, c=0, z=1, 2 SHIFT cycles.
REQ-031 SHALL be covered by: data 0x81, amount 16, fn 10 -> steps 7, 7, 2; result 0x81, c=1, 3 SHIFT cycles.
REQ-032 SHALL be covered by: amount 0 with done_ready held low 4 cycles -> result=data_in, c=0, done_valid high and outputs stable for all 4 cycles, start_ready=0 throughout.
REQ-033 SHALL be covered by: rst_n low mid-SHIFT of amount 31 -> next cycle IDLE, result 0x00, z=1, no done_valid; a new request is then accepted normally.
